// File: rtl/vga_timing_gen.sv
// Single-clock VGA/DVI timing generator with a registered pixel-request stage.
// Sync, data enable and colour pins lag the request by PIPE_DELAY clocks to match the fetch latency.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 1024,
    parameter int H_FRONT    = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BACK     = 160,
    parameter int V_VISIBLE  = 768,
    parameter int V_FRONT    = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 29,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_W    = 8,
    parameter int PIPE_DELAY = 4,
    parameter int CNT_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3*COLOR_W-1:0] color_in,
    output logic                 active,
    output logic [CNT_W-1:0]     active_x,
    output logic [CNT_W-1:0]     active_y,
    output logic                 line_start,
    output logic                 screenend,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam int H_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_LINE - 1);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_VLAST = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_FRAME - 1);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_wrap;

    logic             active_q, line_start_q, screenend_q, hs_req_q, vs_req_q;
    logic [CNT_W-1:0] active_x_q, active_y_q;
    logic             active_d, hs_req_d, vs_req_d;

    logic [PIPE_DELAY-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;
    logic [PIPE_DELAY:0]   hs_chain, vs_chain, de_chain;
    logic [3*COLOR_W-1:0]  rgb_q, rgb_d;

    always_comb begin
        h_wrap   = (h_q == H_LAST);
        h_d      = h_wrap ? '0 : h_q + CNT_W'(1);
        v_d      = v_q;
        if (h_wrap) begin
            v_d  = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
        active_d = (h_q < H_VIS) && (v_q < V_VIS);
        // Sync is carried in pin polarity from the request stage onward.
        hs_req_d = ((h_q >= H_SS) && (h_q < H_SE)) ? HS_POL : ~HS_POL;
        vs_req_d = ((v_q >= V_SS) && (v_q < V_SE)) ? VS_POL : ~VS_POL;
    end

    // chain[0] is the request stage, chain[PIPE_DELAY] drives the pins.
    assign hs_chain = {hs_pipe_q, hs_req_q};
    assign vs_chain = {vs_pipe_q, vs_req_q};
    assign de_chain = {de_pipe_q, active_q};
    assign rgb_d    = de_chain[PIPE_DELAY-1] ? color_in : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q          <= '0;
            v_q          <= '0;
            active_q     <= 1'b0;
            active_x_q   <= '0;
            active_y_q   <= '0;
            line_start_q <= 1'b0;
            screenend_q  <= 1'b0;
            hs_req_q     <= ~HS_POL;
            vs_req_q     <= ~VS_POL;
            hs_pipe_q    <= {PIPE_DELAY{~HS_POL}};
            vs_pipe_q    <= {PIPE_DELAY{~VS_POL}};
            de_pipe_q    <= '0;
            rgb_q        <= '0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            active_q     <= active_d;
            if (active_d) begin
                active_x_q <= h_q;
                active_y_q <= v_q;
            end
            line_start_q <= (h_q == '0);
            screenend_q  <= (h_q == H_VIS) && (v_q == V_VLAST);
            hs_req_q     <= hs_req_d;
            vs_req_q     <= vs_req_d;
            hs_pipe_q    <= hs_chain[PIPE_DELAY-1:0];
            vs_pipe_q    <= vs_chain[PIPE_DELAY-1:0];
            de_pipe_q    <= de_chain[PIPE_DELAY-1:0];
            rgb_q        <= rgb_d;
        end
    end

    assign active     = active_q;
    assign active_x   = active_x_q;
    assign active_y   = active_y_q;
    assign line_start = line_start_q;
    assign screenend  = screenend_q;
    assign hsync      = hs_pipe_q[PIPE_DELAY-1];
    assign vsync      = vs_pipe_q[PIPE_DELAY-1];
    assign de         = de_pipe_q[PIPE_DELAY-1];
    assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 16x8 timing (A), inverted-polarity copy (B), default 1024x768 (C).
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic [23:0] color_a, color_b, color_c;

    logic        act_a, ls_a, se_a, hs_a, vs_a, de_a;
    logic [10:0] ax_a, ay_a;
    logic [7:0]  r_a, g_a, b_a;
    logic        act_b, ls_b, se_b, hs_b, vs_b, de_b;
    logic [10:0] ax_b, ay_b;
    logic [7:0]  r_b, g_b, b_b;
    logic        act_c, ls_c, se_c, hs_c, vs_c, de_c;
    logic [10:0] ax_c, ay_c;
    logic [7:0]  r_c, g_c, b_c;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic        act;
        logic [10:0] ax;
        logic [10:0] ay;
        logic        ls, se, hs, vs, de;
        logic [23:0] rgb;
    } exp_t;

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .color_in(color_a), .active(act_a),
        .active_x(ax_a), .active_y(ay_a), .line_start(ls_a), .screenend(se_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .red(r_a), .green(g_a), .blue(b_a));

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .color_in(color_b), .active(act_b),
        .active_x(ax_b), .active_y(ay_b), .line_start(ls_b), .screenend(se_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .red(r_b), .green(g_b), .blue(b_b));

    vga_timing_gen u_c (
        .clk(clk), .rst_n(rst_n), .color_in(color_c), .active(act_c),
        .active_x(ax_c), .active_y(ay_c), .line_start(ls_c), .screenend(se_c),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .red(r_c), .green(g_c), .blue(b_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel source for A: one clock of fetch latency.
    always @(posedge clk) color_a <= {ax_a[7:0], ay_a[7:0], 8'hA5};

    // Expected A outputs at the sample after the n-th edge since reset release.
    function automatic exp_t model_a(int n);
        exp_t e;
        int h, v, m, hm, vm;
        h = n % 16;
        v = (n / 16) % 8;
        e.act = (h < 8) && (v < 4);
        if (e.act) begin
            e.ax = 11'(h); e.ay = 11'(v);
        end else if (v < 4) begin
            e.ax = 11'd7;  e.ay = 11'(v);
        end else begin
            e.ax = 11'd7;  e.ay = 11'd3;
        end
        e.ls = (h == 0);
        e.se = (h == 8) && (v == 3);
        m = n - 2;
        if (m < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.rgb = 24'h0;
        end else begin
            hm = m % 16;
            vm = (m / 16) % 8;
            e.hs = !((hm >= 10) && (hm < 13));
            e.vs = !((vm >= 5) && (vm < 7));
            e.de = (hm < 8) && (vm < 4);
            e.rgb = e.de ? {8'(hm), 8'(vm), 8'hA5} : 24'h0;
        end
        return e;
    endfunction

    function automatic exp_t obs_a();
        exp_t o;
        o.act = act_a; o.ax = ax_a; o.ay = ay_a; o.ls = ls_a; o.se = se_a;
        o.hs = hs_a; o.vs = vs_a; o.de = de_a; o.rgb = {r_a, g_a, b_a};
        return o;
    endfunction

    task automatic test_reset();
        exp_t rst_e, o;
        rst_e = '{act: 1'b0, ax: 11'd0, ay: 11'd0, ls: 1'b0, se: 1'b0,
                  hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 24'h0};
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            o = obs_a();
            checks++;
            if (o !== rst_e) begin
                errors++;
                $display("FAIL reset_a clk %0d got %h want %h", i, o, rst_e);
            end
            checks++;
            if ({hs_b, vs_b, hs_c, vs_c, de_c} !== 5'b00110) begin
                errors++;
                $display("FAIL reset_bc clk %0d got %b want 00110", i, {hs_b, vs_b, hs_c, vs_c, de_c});
            end
        end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_free_run();
        exp_t e, o;
        int hs_lo = 0, vs_lo = 0, ls_n = 0, se_n = 0;
        for (int i = 0; i < 386; i++) begin
            @(negedge clk);
            e = model_a(cyc);
            o = obs_a();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cycle_a n %0d got %h want %h", cyc, o, e);
            end
            if (cyc == 0) begin
                checks++;
                if ({act_a, ax_a, ay_a} !== {1'b1, 11'd0, 11'd0}) begin
                    errors++;
                    $display("FAIL first_req got %b/%0d/%0d want 1/0/0", act_a, ax_a, ay_a);
                end
            end
            if (cyc == 11 || cyc == 12) begin
                checks++;
                if (hs_a !== (cyc == 11)) begin
                    errors++;
                    $display("FAIL hsync_first_edge n %0d got %b want %b", cyc, hs_a, cyc == 11);
                end
            end
            if (cyc >= 2) begin
                hs_lo += (hs_a == 1'b0) ? 1 : 0;
                vs_lo += (vs_a == 1'b0) ? 1 : 0;
            end
            if (cyc < 384) begin
                ls_n += ls_a ? 1 : 0;
                if (se_a === 1'b1) begin
                    se_n++;
                    checks++;
                    if (cyc % 128 != 56) begin
                        errors++;
                        $display("FAIL screenend_pos got n %0d want n%%128 = 56", cyc);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (hs_lo != 72) begin errors++; $display("FAIL hsync_low_count got %0d want 72", hs_lo); end
        checks++;
        if (vs_lo != 96) begin errors++; $display("FAIL vsync_low_count got %0d want 96", vs_lo); end
        checks++;
        if (ls_n != 24) begin errors++; $display("FAIL line_start_count got %0d want 24", ls_n); end
        checks++;
        if (se_n != 3) begin errors++; $display("FAIL screenend_count got %0d want 3", se_n); end
    endtask

    task automatic test_pixel_data();
        exp_t e;
        int de_n = 0, stray = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = model_a(cyc);
            checks++;
            if ({de_a, r_a, g_a, b_a} !== {e.de, e.rgb}) begin
                errors++;
                $display("FAIL pixel n %0d got de %b rgb %h want de %b rgb %h",
                         cyc, de_a, {r_a, g_a, b_a}, e.de, e.rgb);
            end
            de_n += de_a ? 1 : 0;
            if (!de_a && ({r_a, g_a, b_a} != 24'h0)) stray++;
            cyc++;
        end
        checks++;
        if (de_n != 32) begin errors++; $display("FAIL de_count got %0d want 32", de_n); end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rgb_blank got %0d nonzero want 0", stray); end
    endtask

    task automatic test_polarity();
        exp_t e;
        int hs_hi = 0, vs_hi = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = model_a(cyc);
            checks++;
            if ({hs_b, vs_b} !== {!e.hs, !e.vs}) begin
                errors++;
                $display("FAIL polarity n %0d got %b%b want %b%b", cyc, hs_b, vs_b, !e.hs, !e.vs);
            end
            hs_hi += hs_b ? 1 : 0;
            vs_hi += vs_b ? 1 : 0;
            cyc++;
        end
        checks++;
        if (hs_hi != 24) begin errors++; $display("FAIL pol_hsync_high got %0d want 24", hs_hi); end
        checks++;
        if (vs_hi != 32) begin errors++; $display("FAIL pol_vsync_high got %0d want 32", vs_hi); end
    endtask

    task automatic test_mid_reset();
        exp_t e, o;
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (((cyc + 1) % 16 == 5) && (((cyc + 1) / 16) % 8 == 2)) found = 1;
            cyc++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_align got none want h=5 v=2 within 200 clks");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({act_a, ax_a, ay_a, ls_a, se_a, hs_a, vs_a, de_a, r_a, g_a, b_a} !==
            {1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL mid_reset_a got %h want all cleared, syncs high", obs_a());
        end
        checks++;
        if ({hs_b, vs_b} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_b got %b%b want 00", hs_b, vs_b);
        end
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = model_a(cyc);
            o = obs_a();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL after_reset n %0d got %h want %h", cyc, o, e);
            end
            if (cyc < 2) begin
                checks++;
                if ({de_a, hs_a, vs_a, r_a, g_a, b_a} !== {3'b011, 24'h0}) begin
                    errors++;
                    $display("FAIL refill n %0d got de %b hs %b vs %b rgb %h want 0 1 1 0",
                             cyc, de_a, hs_a, vs_a, {r_a, g_a, b_a});
                end
            end
            cyc++;
        end
    endtask

    task automatic test_default_line();
        int de_n = 0, hs_lo = 0, ls_n = 0, vs_bad = 0, red_bad = 0;
        while (cyc < 2692) begin
            @(negedge clk);
            if (cyc == 1347 || cyc == 1348) begin
                checks++;
                if (de_c !== (cyc == 1348)) begin
                    errors++;
                    $display("FAIL default_de_edge n %0d got %b want %b", cyc, de_c, cyc == 1348);
                end
            end
            if (cyc >= 1348) begin
                de_n  += de_c ? 1 : 0;
                hs_lo += (hs_c == 1'b0) ? 1 : 0;
                ls_n  += ls_c ? 1 : 0;
                if (vs_c !== 1'b1) vs_bad++;
                if (de_c && ({r_c, g_c, b_c} !== 24'h123456)) red_bad++;
            end
            cyc++;
        end
        checks++;
        if (de_n != 1024) begin errors++; $display("FAIL default_de_count got %0d want 1024", de_n); end
        checks++;
        if (hs_lo != 136) begin errors++; $display("FAIL default_hsync_low got %0d want 136", hs_lo); end
        checks++;
        if (ls_n != 1) begin errors++; $display("FAIL default_line_start got %0d want 1", ls_n); end
        checks++;
        if (vs_bad != 0) begin errors++; $display("FAIL default_vsync got %0d asserted want 0", vs_bad); end
        checks++;
        if (red_bad != 0) begin errors++; $display("FAIL default_rgb got %0d bad want 0", red_bad); end
    endtask

    initial begin
        rst_n   = 1'b0;
        color_b = 24'h0;
        color_c = 24'h123456;
        test_reset();
        test_free_run();
        test_pixel_data();
        test_polarity();
        test_mid_reset();
        test_default_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
